// File: rtl/fsm_1_detector_if.sv
// Bus between the serial source and the 1010 detector. The bus carries the
// data bit, the detect flag and a debug copy of the FSM state register.
interface fsm_1_detector_if;
  // There is no valid/ready pair. The detector takes one datain bit on every
  // rising clk edge while reset is high, and the source is always ready.
  // The value of yes belongs to the bit consumed on the previous edge.
  logic       datain;
  logic       yes;
  logic [2:0] state;

  modport master (
    output datain,
    input  yes,
    input  state
  );

  modport slave (
    input  datain,
    output yes,
    output state
  );
endinterface

// File: rtl/fsm_1_detector.sv
// Moore FSM that watches a serial stream for the pattern 1010. Overlapping
// matches count. yes is a pure decode of the state register.
module fsm_1_detector (
  input  logic              clk,
  input  logic              reset,
  fsm_1_detector_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S10  = 3'd2,
    S101 = 3'd3,
    DET  = 3'd4
  } state_e;

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each state holds the longest prefix of 1010 that the received bits end in.
  // DET falls back to S101 on a 1 so that overlapping matches are detected.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.datain ? S1   : IDLE;
      S1:      state_d = bus.datain ? S1   : S10;
      S10:     state_d = bus.datain ? S101 : IDLE;
      S101:    state_d = bus.datain ? S1   : DET;
      DET:     state_d = bus.datain ? S101 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.yes   = (state_q == DET);
  assign bus.state = state_q;

endmodule

// File: tb/tb_fsm_1_detector.sv
// Directed bench for the 1010 detector. A shift-register reference model
// fills a queue of expected yes values, and each entry is checked one edge later.
module tb_fsm_1_detector;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [3:0] hist;
  logic [0:0] exp_q[$];

  fsm_1_detector_if bus ();

  fsm_1_detector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic drive_bit(input logic b, input string tag);
    logic [0:0] e;
    @(negedge clk);
    bus.datain = b;
    hist = {hist[2:0], b};
    exp_q.push_back((hist == 4'b1010) ? 1'b1 : 1'b0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {2'b00, bus.yes}, {2'b00, e});
    end
  endtask

  task automatic drive_seq(input logic [7:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(bits[i], tag);
    end
  endtask

  task automatic hold_in_reset(input logic b);
    @(negedge clk);
    bus.datain = b;
    @(posedge clk);
    #1;
    chk("t1_yes_in_reset", {2'b00, bus.yes}, 3'd0);
    chk("t1_state_in_reset", bus.state, 3'd0);
  endtask

  // Pulse reset between two edges and check that it takes effect with no edge.
  task automatic async_reset_pulse(input string tag);
    #1 reset = 1'b0;
    #1;
    chk({tag, "_yes"}, {2'b00, bus.yes}, 3'd0);
    chk({tag, "_state"}, bus.state, 3'd0);
    #1 reset = 1'b1;
    hist = 4'b0000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hist     = 4'b0000;
    reset    = 1'b0;
    bus.datain = 1'b0;
    #2;
    chk("reset_yes", {2'b00, bus.yes}, 3'd0);
    chk("reset_state", bus.state, 3'd0);

    // 1: pattern presented while reset is held low
    hold_in_reset(1'b1);
    hold_in_reset(1'b0);
    hold_in_reset(1'b1);
    hold_in_reset(1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 2: single match, then trailing non-matching bits
    drive_seq(8'b1010_0011, 8, "t2_single");
    // 3: overlapping matches
    drive_seq(8'b0010_1010, 6, "t3_overlap");
    // 4: repeated ones before the match
    drive_seq(8'b0001_1010, 5, "t4_s1_loop");

    // 5: partial match cleared by a reset pulse
    drive_seq(8'b0000_0101, 3, "t5_prefix");
    async_reset_pulse("t5_mid_reset");
    drive_bit(1'b0, "t5_after_reset");
    drive_seq(8'b0000_1010, 4, "t5_rematch");

    // 6: reset asserted while yes is high
    drive_seq(8'b0000_1010, 4, "t6_match");
    chk("t6_state_det", bus.state, 3'd4);
    async_reset_pulse("t6_reset_in_det");

    // Random tail checked against the reference model
    for (int i = 0; i < 40; i++) begin
      drive_bit(1'($urandom_range(0, 1)), "rand");
    end

    chk("queue_drained", 3'(exp_q.size()), 3'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
